// File: rtl/t_toggle_hs_rx.sv
// Receiving end of a two-phase (toggle) handshake: synchronises req_tgl, captures one word per toggle,
// offers it on a valid/ready port and toggles ack_tgl when it is consumed. Option macro: T_TOGGLE_HS_RX_COUNT_EN.
module t_toggle_hs_rx #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_tgl,
  input  logic [DATA_W-1:0] req_data,
  output logic              ack_tgl,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       xfer_count,
  output logic              proto_err,
  output logic              dbg_state
);

  // Handshake: a word moves to the consumer on every rising clk edge where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that edge.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                req_q, req_d;
  logic                ack_q, ack_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                req_s;
  logic                req_edge;
  logic                pending;

  assign req_s    = sync_q[SYNC_STAGES-1];
  assign req_edge = req_s ^ req_q;
  assign pending  = req_s ^ ack_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], req_tgl};
    req_d   = req_s;
    state_d = state_q;
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    // A new toggle while a word is still held means the sender did not wait for the ack.
    err_d   = err_q | ((state_q == HOLD) && req_edge);
    case (state_q)
      IDLE: begin
        if (pending) begin
          data_d  = req_data;
          valid_d = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q  <= '0;
      req_q   <= 1'b0;
      state_q <= IDLE;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      req_q   <= req_d;
      state_q <= state_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef T_TOGGLE_HS_RX_COUNT_EN
  logic        hs_done;
  logic [15:0] cnt_q, cnt_d;

  assign hs_done = (state_q == HOLD) && out_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (hs_done) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign xfer_count = cnt_q;
`else
  assign xfer_count = 16'd0;
`endif

  assign ack_tgl   = ack_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign proto_err = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_t_toggle_hs_rx.sv
// Directed bench for t_toggle_hs_rx (SYNC_STAGES=2): vector table for single transfer and backpressure,
// hand-written sequences for bursts, violations, reset mid-transfer and counter wrap.
module tb_t_toggle_hs_rx;
  localparam int DATA_W = 8;

  logic              clk;
  logic              rst_n;
  logic              req_tgl;
  logic [DATA_W-1:0] req_data;
  logic              ack_tgl;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       xfer_count;
  logic              proto_err;
  logic              dbg_state;

  t_toggle_hs_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .req_data(req_data),
    .ack_tgl(ack_tgl), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .xfer_count(xfer_count), .proto_err(proto_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit mon_en = 1'b0;

  typedef struct {
    logic              req;
    logic [DATA_W-1:0] data;
    logic              rdy;
    int                reps;
    logic              valid;
    logic [DATA_W-1:0] odata;
    logic              ack;
    int                cnt;
    logic              err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt(input int n);
`ifdef T_TOGGLE_HS_RX_COUNT_EN
    return n[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic v, input logic [DATA_W-1:0] d,
                            input logic a, input int c, input logic e);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".data"},  32'(out_data),  32'(d));
    check({tag, ".ack"},   32'(ack_tgl),   32'(a));
    check({tag, ".count"}, 32'(xfer_count), 32'(exp_cnt(c)));
    check({tag, ".err"},   32'(proto_err), 32'(e));
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_tgl   = 1'b0;
    req_data  = '0;
    out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // driver: sender model toggles once and waits for the matching ack
  task automatic send_word(input logic [DATA_W-1:0] d);
    int k;
    req_data = d;
    if (mon_en) exp_q.push_back(d);
    req_tgl = ~req_tgl;
    k = 0;
    while (ack_tgl !== req_tgl && k < 50) begin
      step();
      k++;
    end
    check("send_ack_timeout", 32'(ack_tgl), 32'(req_tgl));
  endtask

  // scoreboard: every accepted word must match the next expected word
  always @(negedge clk) begin
    if (mon_en && rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mon_unexpected: got word %0h with empty expected queue", out_data);
      end else begin
        check("mon_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int n_fast;
    bit cnt_bad;

    vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1,  1'b0, 8'h00, 1'b0, 0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA5, 1'b1, 1,  1'b0, 8'h00, 1'b0, 0, 1'b0};
    vecs[2]  = '{1'b1, 8'hA5, 1'b1, 1,  1'b1, 8'hA5, 1'b0, 0, 1'b0};
    vecs[3]  = '{1'b1, 8'hA5, 1'b1, 1,  1'b0, 8'hA5, 1'b1, 1, 1'b0};
    vecs[4]  = '{1'b1, 8'hA5, 1'b1, 1,  1'b0, 8'hA5, 1'b1, 1, 1'b0};
    vecs[5]  = '{1'b0, 8'h3C, 1'b0, 1,  1'b0, 8'hA5, 1'b1, 1, 1'b0};
    vecs[6]  = '{1'b0, 8'h3C, 1'b0, 1,  1'b0, 8'hA5, 1'b1, 1, 1'b0};
    vecs[7]  = '{1'b0, 8'h3C, 1'b0, 1,  1'b1, 8'h3C, 1'b1, 1, 1'b0};
    vecs[8]  = '{1'b0, 8'hFF, 1'b0, 20, 1'b1, 8'h3C, 1'b1, 1, 1'b0};
    vecs[9]  = '{1'b0, 8'hFF, 1'b1, 1,  1'b0, 8'h3C, 1'b0, 2, 1'b0};
    vecs[10] = '{1'b0, 8'hFF, 1'b1, 3,  1'b0, 8'h3C, 1'b0, 2, 1'b0};

    // reset held for 10 cycles with req_tgl low
    rst_n     = 1'b0;
    req_tgl   = 1'b0;
    req_data  = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("reset_valid", 32'(out_valid), 32'd0);
    end
    check_outs("reset", 1'b0, 8'h00, 1'b0, 0, 1'b0);
    check("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // single transfer then backpressure
    for (int i = 0; i < 11; i++) begin
      req_tgl   = vecs[i].req;
      req_data  = vecs[i].data;
      out_ready = vecs[i].rdy;
      for (int r = 0; r < vecs[i].reps; r++) begin
        step();
        check_outs($sformatf("vec%0d", i), vecs[i].valid, vecs[i].odata, vecs[i].ack,
                   vecs[i].cnt, vecs[i].err);
      end
    end

    // burst of 4 well-behaved words
    do_reset();
    out_ready = 1'b1;
    mon_en    = 1'b1;
    for (int i = 1; i <= 4; i++) send_word(8'(i));
    step();
    step();
    mon_en = 1'b0;
    check_outs("burst", 1'b0, 8'h04, 1'b0, 4, 1'b0);
    check("burst_queue_empty", 32'(exp_q.size()), 32'd0);

    // violation while held, then clean transfers keep the sticky flag
    do_reset();
    req_data = 8'h11;
    req_tgl  = 1'b1;
    step(); step(); step();
    check_outs("viol_hold", 1'b1, 8'h11, 1'b0, 0, 1'b0);
    check("viol_state", 32'(dbg_state), 32'd1);
    req_tgl = 1'b0;
    step(); step();
    check("viol_err_not_yet", 32'(proto_err), 32'd0);
    step();
    check_outs("viol_err", 1'b1, 8'h11, 1'b0, 0, 1'b1);
    out_ready = 1'b1;
    req_data  = 8'h22;
    step();
    check_outs("viol_hs", 1'b0, 8'h11, 1'b1, 1, 1'b1);
    step();
    check_outs("viol_next", 1'b1, 8'h22, 1'b1, 1, 1'b1);
    step();
    check_outs("viol_next_hs", 1'b0, 8'h22, 1'b0, 2, 1'b1);
    send_word(8'h33);
    step(); step();
    check_outs("viol_sticky", 1'b0, 8'h33, 1'b1, 3, 1'b1);
    rst_n = 1'b0;
    step();
    check_outs("viol_cleared", 1'b0, 8'h00, 1'b0, 0, 1'b0);

    // req edge in the very cycle the handshake completes
    do_reset();
    req_data = 8'h44;
    req_tgl  = 1'b1;
    step(); step(); step();
    check_outs("simul_hold", 1'b1, 8'h44, 1'b0, 0, 1'b0);
    req_tgl = 1'b0;
    step(); step();
    out_ready = 1'b1;
    step();
    check_outs("simul_hs", 1'b0, 8'h44, 1'b1, 1, 1'b1);
    step();
    check_outs("simul_next", 1'b1, 8'h44, 1'b1, 1, 1'b1);
    step();
    check_outs("simul_next_hs", 1'b0, 8'h44, 1'b0, 2, 1'b1);

    // reset while a word is held; sender level still high afterwards
    do_reset();
    req_data = 8'h55;
    req_tgl  = 1'b1;
    step(); step(); step();
    check_outs("rmid_hold", 1'b1, 8'h55, 1'b0, 0, 1'b0);
    rst_n = 1'b0;
    step();
    check_outs("rmid_reset", 1'b0, 8'h00, 1'b0, 0, 1'b0);
    check("rmid_state", 32'(dbg_state), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rmid_r0_valid", 32'(out_valid), 32'd0);
    step();
    check("rmid_r1_valid", 32'(out_valid), 32'd0);
    step();
    check_outs("rmid_r2", 1'b1, 8'h55, 1'b0, 0, 1'b0);

    // back-to-back toggles every 2 cycles with out_ready held high
    do_reset();
    out_ready = 1'b1;
    req_data  = 8'h5A;
    mon_en    = 1'b1;
    cnt_bad   = 1'b0;
`ifdef T_TOGGLE_HS_RX_COUNT_EN
    n_fast = 65536;
`else
    n_fast = 300;
`endif
    for (int i = 0; i < n_fast; i++) begin
      exp_q.push_back(8'h5A);
      req_tgl = ~req_tgl;
      step();
      if (xfer_count !== exp_cnt(0) && n_fast == 300) cnt_bad = 1'b1;
      step();
      if (xfer_count !== exp_cnt(0) && n_fast == 300) cnt_bad = 1'b1;
    end
    for (int i = 0; i < 6; i++) step();
    mon_en = 1'b0;
    check_outs("fast_end", 1'b0, 8'h5A, 1'b0, n_fast, 1'b0);
    check("fast_queue_empty", 32'(exp_q.size()), 32'd0);
    check("fast_count_static", 32'(cnt_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/t_toggle_hs_rx.md
# t_toggle_hs_rx

Receiving end of a two-phase (toggle) handshake. A sender built around a T flip-flop flips `req_tgl` once per word. This block synchronises that level into the local `clk` domain and recovers each toggle as exactly one transfer. It presents the word on a local valid/ready port and toggles `ack_tgl` back to the sender once the word is consumed. It sits at the clock-domain boundary between a toggle-signalling producer and local consumer logic.

## Interface
- `DATA_W`, 8: width of the transferred word.
- `SYNC_STAGES`, 2: flops in the `req_tgl` synchroniser; legal range 2..4.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_tgl` in 1: request level from the sender, asynchronous; each transition is one request.
- `req_data` in DATA_W: sender word; held stable from the `req_tgl` transition until `ack_tgl` matches.
- `ack_tgl` out 1: acknowledge level; toggles once per consumed word.
- `out_data` out DATA_W: captured word.
- `out_valid` out 1: `out_data` holds an unconsumed word.
- `out_ready` in 1: consumer accepts the word.
- `xfer_count` out 16: number of completed transfers.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- Synchroniser: `req_s` is the output of the last of SYNC_STAGES flops fed by `req_tgl`.
- `req_q` is `req_s` delayed one cycle. A req edge is `req_s ^ req_q`.
- Pending: `req_s != ack_tgl`.
- FSM state IDLE:
  - If pending, capture `req_data` into `out_data`, set `out_valid`, and go to HOLD.
  - Otherwise stay in IDLE; `out_data` holds its last value.
- FSM state HOLD:
  - `out_valid`=1 and `out_data` is frozen.
  - When `out_ready`=1: clear `out_valid`, invert `ack_tgl`, increment `xfer_count`, and go to IDLE.
- `out_valid` never drops without a handshake, and `out_data` never changes while `out_valid`=1.
- Protocol violation: a req edge while in HOLD sets `proto_err`.
  - The bit is sticky until reset.
  - The current transfer still completes normally.
  - After the ack toggle, any remaining mismatch is treated as a new request.
- Simultaneous events:
  - A req edge in the same cycle the HOLD handshake completes is a violation; it sets `proto_err`.
  - The FSM still returns to IDLE, where the mismatch is taken as the next request.
- `xfer_count` wraps from 0xFFFF to 0x0000 without a flag.
- Reset value of every output and register is 0: `ack_tgl`, `out_valid`, `out_data`, `xfer_count`, `proto_err`, all synchroniser flops, `req_q`. State resets to IDLE.
- Reset mid-operation:
  - A word held in HOLD is discarded with no ack.
  - A sender whose `req_tgl` is still 1 after reset is seen as one new request, SYNC_STAGES+1 cycles later. Senders are reset together with this block.

## Timing
- Request latency: when `req_tgl` changes before edge k, `req_s` changes at edge k+SYNC_STAGES-1 and `out_valid`=1 after edge k+SYNC_STAGES.
- Data is sampled at that same edge k+SYNC_STAGES.
- `req_data` is quasi-static and is not synchronised; the sender guarantees stability.
- Handshake: `out_valid`&&`out_ready` at edge m means `out_valid`=0 and `ack_tgl` toggled after edge m. `xfer_count` updates at the same edge.
- `out_ready` may be held high. Minimum spacing is one IDLE cycle between consecutive HOLD periods, i.e. at most one word per 2 cycles locally.
- The round trip is bounded by the sender's own synchroniser on `ack_tgl`, which is outside this block.
- `proto_err` rises one cycle after the offending req edge is seen on `req_s`.

## Configuration
- `T_TOGGLE_HS_RX_COUNT_EN`, defined: the 16-bit `xfer_count` register is built as described.
- Not defined: no counter is built, `xfer_count` is tied to 0, and all other behaviour is unchanged.

## Test plan
- Reset with `req_tgl`=0: all outputs 0 and state IDLE, held for 10 cycles with `out_valid` staying 0.
- Single transfer, SYNC_STAGES=2:
  - Stimulus: `req_data`=0xA5, `req_tgl` 0→1 before edge 5, `out_ready`=1.
  - Response: `out_valid`=1 after edge 7 with `out_data`=0xA5, then `ack_tgl`=1 and `out_valid`=0 after edge 8, and `xfer_count`=1.
- Backpressure: `out_ready`=0 for 20 cycles → `out_valid` and `out_data` stable and `ack_tgl` unchanged; raising `out_ready` completes exactly one transfer.
- Burst of 4 well-behaved toggles (0x01..0x04) with a sender model waiting on `ack_tgl`: words 0x01..0x04 are received in order, `xfer_count`=4, `ack_tgl`=0, `proto_err`=0.
- Violation: `req_tgl` toggles again while in HOLD with `out_ready`=0 → `proto_err`=1 and stays 1 after further clean transfers until `rst_n`=0.
- Wrap, with the macro defined: preload by running 65536 transfers → `xfer_count` returns to 0x0000. With the macro undefined, `xfer_count` stays 0 throughout.
